// File: rtl/iterative_multiplier_if.sv
// ============================================================================
// Module  : iterative_multiplier_if
// Brief   : Request/response bundle for the iterative shift-and-add multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface iterative_multiplier_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   i_multiplicand;
  logic [DATA_W-1:0]   i_multiplier;
  logic                i_valid;
  logic                o_ready;
  logic [2*DATA_W-1:0] o_product;
  logic                o_valid;

  modport master (
    output i_multiplicand, i_multiplier, i_valid,
    input  o_ready, o_product, o_valid
  );

  modport slave (
    input  i_multiplicand, i_multiplier, i_valid,
    output o_ready, o_product, o_valid
  );
endinterface

`default_nettype wire

// File: rtl/iterative_multiplier.sv
// ============================================================================
// Module  : iterative_multiplier
// Brief   : Unsigned shift-and-add multiplier, one product bit per clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_multiplier #(
  parameter int DATA_W = 32
) (
  input  wire logic               i_clk,
  input  wire logic               i_rst,
  iterative_multiplier_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state;
  logic                ready;
  logic                valid;
  logic [DATA_W-1:0]   mcand;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] product;
  logic [CNT_W-1:0]    count;

  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] acc_next;

  // Upper half plus the conditional addend keeps its carry, which becomes the new MSB after the shift.
  always_comb begin
    sum      = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : {(DATA_W+1){1'b0}});
    acc_next = {sum, acc[DATA_W-1:1]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      ready   <= 1'b1;
      valid   <= 1'b0;
      mcand   <= '0;
      acc     <= '0;
      product <= '0;
      count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_valid) begin
            mcand <= bus.i_multiplicand;
            acc   <= {{DATA_W{1'b0}}, bus.i_multiplier};
            count <= '0;
            ready <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          count <= count + CNT_W'(1);
          if (count == LAST_ITER) begin
            product <= acc_next;
            valid   <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_valid   = valid;
  assign bus.o_product = product;

endmodule

`default_nettype wire

// File: tb/tb_iterative_multiplier.sv
// ============================================================================
// Module  : tb_iterative_multiplier
// Brief   : Scoreboard bench for iterative_multiplier with DATA_W=32.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iterative_multiplier;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  iterative_multiplier_if #(.DATA_W(DATA_W)) bus ();

  iterative_multiplier #(.DATA_W(DATA_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb[$];
  logic [63:0] hold_val = '0;
  int          busy_left = 0;
  bit          started = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference timing: acceptance at edge N -> valid after edge N+32, ready after N+33.
  always @(negedge clk) begin
    logic [63:0] exp;
    if (busy_left > 0) busy_left--;
    if (started) begin
      check("ready", {63'b0, bus.o_ready}, {63'b0, busy_left == 0});
      check("valid", {63'b0, bus.o_valid}, {63'b0, busy_left == 1});
      if (bus.o_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          exp = sb.pop_front();
          check("product", bus.o_product, exp);
          hold_val = exp;
        end
      end else begin
        check("product_hold", bus.o_product, hold_val);
      end
    end
    if (rst) begin
      started   = 1'b1;
      busy_left = 0;
      hold_val  = '0;
      sb.delete();
    end else if (started && bus.i_valid && bus.o_ready) begin
      sb.push_back({32'b0, bus.i_multiplicand} * {32'b0, bus.i_multiplier});
      busy_left = 34;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit keep);
    int n;
    bus.i_multiplicand = a;
    bus.i_multiplier   = b;
    bus.i_valid        = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.o_ready) break;
      n++;
      if (n > 100) begin
        check("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(output logic [63:0] p);
    int n;
    p = 'x;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.o_valid) begin
        p = bus.o_product;
        break;
      end
      n++;
      if (n > 100) begin
        check("valid_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  initial begin
    logic [63:0] p;
    int n;
    bus.i_valid        = 1'b0;
    bus.i_multiplicand = '0;
    bus.i_multiplier   = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {63'b0, bus.o_ready}, 64'd1);
    check("reset_valid", {63'b0, bus.o_valid}, 64'd0);
    check("reset_product", bus.o_product, 64'd0);

    send(32'd7, 32'd6, 1'b0);
    wait_valid(p);
    check("basic_7x6", p, 64'd42);

    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_valid(p);
    check("max_operands", p, 64'hFFFF_FFFE_0000_0001);

    send(32'd0, 32'h1234_5678, 1'b0);
    wait_valid(p);
    check("zero_operand", p, 64'd0);

    send(32'h1234_5678, 32'd1, 1'b0);
    wait_valid(p);
    check("identity", p, 64'h0000_0000_1234_5678);

    // Busy request mid-run must be dropped; late operand changes must not leak in.
    send(32'd3, 32'd5, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.i_multiplicand = 32'd9;
    bus.i_multiplier   = 32'd9;
    bus.i_valid        = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid        = 1'b0;
    bus.i_multiplicand = 32'hAAAA_5555;
    bus.i_multiplier   = 32'h5555_AAAA;
    wait_valid(p);
    check("busy_ignored", p, 64'd15);
    @(negedge clk);

    send(32'hDEAD_BEEF, 32'h10, 1'b0);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_ready", {63'b0, bus.o_ready}, 64'd1);
    check("midreset_product", bus.o_product, 64'd0);
    check("midreset_valid", {63'b0, bus.o_valid}, 64'd0);
    repeat (40) @(negedge clk);

    send(32'd2, 32'd3, 1'b0);
    wait_valid(p);
    check("after_reset_2x3", p, 64'd6);

    for (int i = 0; i < 1500; i++) begin
      send($urandom, $urandom, 1'b1);
    end
    bus.i_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
